m_gen_scheduler: RTL and testbench
==================================

// Module: m_gen_scheduler
// PURPOSE
//  Frame-level sequencer for the M-generation datapath (alpha2xinitial -> candidategen -> F_case2).
//  Requests one alpha column load, waits for x_initial, then issues start_gen/J_index for every
//  index 0..J-1 and drains all F_value results per index. Tracks minimum F and its position; pulses done.
// PARAMETERS
//  J      14                 columns per row; number of J_index sweeps per frame
//  I      7                  rows (informational; sizes nothing here)
//  A      2                  alphabet size (informational)
//  FW     64                 F_value width
//  CW     16                 per-index candidate/result counter width
//  TMO    1024               watchdog limit in cycles (used only with M_GEN_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous active-low reset
//  cmd_start      in   1          1-cycle frame start request
//  busy           out  1          high from accepted cmd_start until done
//  alpha_ld_req   out  1          level: alpha column streaming allowed
//  alpha_ld_last  in   1          alpha_u_col_tvalid && tlast observed
//  x_init_tvalid  in   1          x_initial valid from alpha2xinitial
//  start_gen      out  1          1-cycle pulse to candidategen
//  J_index        out  $clog2(J)  index for current sweep
//  cand_tvalid    in   1          candidate_row_tvalid
//  cand_tlast     in   1          candidate_row_tlast
//  f_tvalid       in   1          F_value_tvalid
//  f_value        in   FW         F_value (unsigned)
//  best_f         out  FW         minimum F of the frame
//  best_j         out  $clog2(J)  J_index of best_f
//  best_k         out  CW         candidate ordinal within that index
//  done           out  1          1-cycle pulse; best_* valid from this cycle until next cmd_start
//  err            out  1          sticky; cleared by accepted cmd_start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, best_f all-ones; counters 0. Reset mid-frame aborts, no done.
//  States: IDLE -> LOAD (cmd_start) -> WAIT_X (alpha_ld_last) -> GEN (x_init_tvalid) -> DRAIN
//    (cand_tvalid&&cand_tlast) -> GEN if J_index<J-1 (J_index++) else DONE -> IDLE (after 1 cycle).
//  cmd_start outside IDLE: ignored. alpha_ld_req=1 only in LOAD.
//  start_gen: exactly one pulse, the cycle after entering GEN; J_index stable through GEN/DRAIN.
//  cand_cnt increments per cand_tvalid in GEN; f_cnt increments per f_tvalid in GEN/DRAIN.
//  DRAIN exits when f_cnt==cand_cnt (same-cycle f_tvalid counted first); both counters clear on exit.
//  Min: f_value < best_f strictly -> update best_f/best_j/best_k=f_cnt; ties keep earlier.
//  best_f reset to all-ones at accepted cmd_start.
//  err set on: f_tvalid or cand_tvalid in IDLE/LOAD/WAIT_X; f_cnt>cand_cnt; counter wrap at 2^CW-1.
//  err does not stop the sequence. done asserted in DONE state; busy drops same cycle as done.
//  Simultaneous cand_tlast and f_tvalid: both counted in that cycle.
// CONFIGURATION
//  M_GEN_SCHED_TIMEOUT_EN defined: watchdog counts cycles without cand_tvalid/f_tvalid/x_init_tvalid/
//   alpha_ld_last while busy; at TMO sets err, goes to IDLE, pulses done with best_* as-is.
//  Undefined: no watchdog logic; frame waits indefinitely.
// STRUCTURE
//  m_gen_pkg: state enum (IDLE,LOAD,WAIT_X,GEN,DRAIN,DONE), JW=$clog2(J), FW/CW defaults.
//  Sub-module f_min_tracker: clear, valid, value, ordinal in -> registered best value/ordinal/tag.
//  Top: FSM, counters, error logic, optional watchdog.
// TESTING
//  1. J=14, 3 cands/index, F=100-k per index -> 14 start_gen pulses, done, best_f=98, best_j=0, best_k=2.
//  2. Equal F=5 everywhere -> best_j=0, best_k=0 (tie keeps first).
//  3. F results arrive 20 cycles after cand_tlast -> stays in DRAIN, no start_gen until f_cnt==cand_cnt.
//  4. f_tvalid pulse while IDLE -> err=1; next cmd_start clears err; frame completes normally.
//  5. rst_n low mid GEN at J_index=6 -> next cycle IDLE, outputs 0, no done; new frame starts at J_index 0.
//  6. TIMEOUT_EN, TMO=64, stall after x_init -> err=1 and done at cycle 64 of silence; without macro, busy stays 1.

Source files
------------

// File: rtl/m_gen_pkg.sv
// Shared types and default sizes for the M-generation frame scheduler.
package m_gen_pkg;

  localparam int J_DEF  = 14;
  localparam int I_ROWS = 7;
  localparam int A_SIZE = 2;
  localparam int FW_DEF = 64;
  localparam int CW_DEF = 16;
  localparam int JW     = $clog2(J_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT_X = 3'd2,
    GEN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } sched_state_e;

  function automatic logic is_busy_state(input sched_state_e s);
    return (s == LOAD) || (s == WAIT_X) || (s == GEN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/m_gen_scheduler_if.sv
// Datapath-side handshake bundle between the scheduler (master) and the M-generation datapath (slave).
interface m_gen_scheduler_if;
  import m_gen_pkg::*;

  logic              alpha_ld_req;
  logic              alpha_ld_last;
  logic              x_init_tvalid;
  logic              start_gen;
  logic [JW-1:0]     J_index;
  logic              cand_tvalid;
  logic              cand_tlast;
  logic              f_tvalid;
  logic [FW_DEF-1:0] f_value;

  modport master (
    output alpha_ld_req, start_gen, J_index,
    input  alpha_ld_last, x_init_tvalid, cand_tvalid, cand_tlast, f_tvalid, f_value
  );

  modport slave (
    input  alpha_ld_req, start_gen, J_index,
    output alpha_ld_last, x_init_tvalid, cand_tvalid, cand_tlast, f_tvalid, f_value
  );

endinterface

// File: rtl/m_gen_scheduler_f_min_tracker.sv
// Running-minimum register: remembers the smallest value seen since clear plus its ordinal and tag.
module f_min_tracker #(
  parameter int VW = 64,
  parameter int OW = 16,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          valid,
  input  logic [VW-1:0] value,
  input  logic [OW-1:0] ordinal,
  input  logic [TW-1:0] tag,
  output logic [VW-1:0] best_value,
  output logic [OW-1:0] best_ordinal,
  output logic [TW-1:0] best_tag
);

  logic [VW-1:0] best_value_r;
  logic [OW-1:0] best_ordinal_r;
  logic [TW-1:0] best_tag_r;

  // Strictly-smaller update so ties keep the earliest winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_value_r   <= {VW{1'b1}};
      best_ordinal_r <= {OW{1'b0}};
      best_tag_r     <= {TW{1'b0}};
    end else if (clear) begin
      best_value_r   <= {VW{1'b1}};
      best_ordinal_r <= {OW{1'b0}};
      best_tag_r     <= {TW{1'b0}};
    end else if (valid && (value < best_value_r)) begin
      best_value_r   <= value;
      best_ordinal_r <= ordinal;
      best_tag_r     <= tag;
    end
  end

  assign best_value   = best_value_r;
  assign best_ordinal = best_ordinal_r;
  assign best_tag     = best_tag_r;

endmodule

// File: rtl/m_gen_scheduler.sv
// Frame sequencer: alpha load, x_initial wait, J sweeps of start_gen/drain, min-F tracking.
// Optional watchdog enabled by defining M_GEN_SCHED_TIMEOUT_EN.
module m_gen_scheduler
  import m_gen_pkg::*;
#(
  parameter int J  = J_DEF,
  parameter int FW = FW_DEF,
  parameter int CW = CW_DEF
`ifdef M_GEN_SCHED_TIMEOUT_EN
  , parameter int TMO = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_start,
  output logic                busy,
  m_gen_scheduler_if.master   bus,
  output logic [FW-1:0]       best_f,
  output logic [JW-1:0]       best_j,
  output logic [CW-1:0]       best_k,
  output logic                done,
  output logic                err
);

  localparam logic [JW-1:0] J_LAST = JW'(J - 1);

  sched_state_e  state_r, fsm_next_s, next_s;
  logic [JW-1:0] j_idx_r;
  logic [CW-1:0] cand_cnt_r, f_cnt_r, cand_inc_s, f_inc_s;
  logic          busy_r, done_r, err_r, alpha_req_r, start_gen_r;
  logic          accept_s, c_take_s, f_take_s, early_s, over_s, wrap_s;
  logic          drain_exit_s, wd_fire_s;

  // Event decode and next-state selection.
  always_comb begin
    accept_s     = (state_r == IDLE) && cmd_start;
    c_take_s     = (state_r == GEN) && bus.cand_tvalid;
    f_take_s     = ((state_r == GEN) || (state_r == DRAIN)) && bus.f_tvalid;
    cand_inc_s   = cand_cnt_r + CW'(c_take_s);
    f_inc_s      = f_cnt_r + CW'(f_take_s);
    early_s      = ((state_r == IDLE) || (state_r == LOAD) || (state_r == WAIT_X)) &&
                   (bus.f_tvalid || bus.cand_tvalid);
    over_s       = ((state_r == GEN) || (state_r == DRAIN)) && (f_inc_s > cand_inc_s);
    wrap_s       = (c_take_s && (cand_cnt_r == {CW{1'b1}})) ||
                   (f_take_s && (f_cnt_r == {CW{1'b1}}));
    drain_exit_s = (state_r == DRAIN) && (f_inc_s == cand_cnt_r);
    fsm_next_s   = state_r;
    case (state_r)
      IDLE:    if (accept_s) fsm_next_s = LOAD; else fsm_next_s = IDLE;
      LOAD:    if (bus.alpha_ld_last) fsm_next_s = WAIT_X; else fsm_next_s = LOAD;
      WAIT_X:  if (bus.x_init_tvalid) fsm_next_s = GEN; else fsm_next_s = WAIT_X;
      GEN:     if (bus.cand_tvalid && bus.cand_tlast) fsm_next_s = DRAIN; else fsm_next_s = GEN;
      DRAIN: begin
        if (drain_exit_s) begin
          if (j_idx_r == J_LAST) fsm_next_s = DONE; else fsm_next_s = GEN;
        end else begin
          fsm_next_s = DRAIN;
        end
      end
      DONE:    fsm_next_s = IDLE;
      default: fsm_next_s = IDLE;
    endcase
    next_s = wd_fire_s ? IDLE : fsm_next_s;
  end

  // State, sweep index, per-index counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      j_idx_r     <= {JW{1'b0}};
      cand_cnt_r  <= {CW{1'b0}};
      f_cnt_r     <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      alpha_req_r <= 1'b0;
      start_gen_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      busy_r      <= is_busy_state(next_s);
      done_r      <= (next_s == DONE) || wd_fire_s;
      alpha_req_r <= (next_s == LOAD);
      start_gen_r <= (next_s == GEN) && (state_r != GEN);
      if (accept_s) begin
        j_idx_r <= {JW{1'b0}};
      end else if (drain_exit_s && (j_idx_r != J_LAST)) begin
        j_idx_r <= j_idx_r + {{(JW-1){1'b0}}, 1'b1};
      end
      if (accept_s || drain_exit_s || wd_fire_s) begin
        cand_cnt_r <= {CW{1'b0}};
        f_cnt_r    <= {CW{1'b0}};
      end else begin
        cand_cnt_r <= cand_inc_s;
        f_cnt_r    <= f_inc_s;
      end
      // A fresh frame forgets old faults but still flags one arriving in the start cycle.
      if (accept_s) begin
        err_r <= early_s;
      end else begin
        err_r <= err_r | early_s | over_s | wrap_s | wd_fire_s;
      end
    end
  end

`ifdef M_GEN_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TMO);
  logic [WDW-1:0] wd_cnt_r;
  logic           wd_act_s;

  // Silence detector: any datapath handshake restarts the count.
  always_comb begin
    wd_act_s  = bus.cand_tvalid || bus.f_tvalid || bus.x_init_tvalid || bus.alpha_ld_last;
    wd_fire_s = is_busy_state(state_r) && !wd_act_s && (wd_cnt_r == WDW'(TMO - 1));
  end

  // Watchdog counter, idle outside busy states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_r <= {WDW{1'b0}};
    end else if (!is_busy_state(state_r) || wd_act_s || wd_fire_s) begin
      wd_cnt_r <= {WDW{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + {{(WDW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  f_min_tracker #(.VW(FW), .OW(CW), .TW(JW)) u_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept_s),
    .valid        (f_take_s),
    .value        (bus.f_value),
    .ordinal      (f_cnt_r),
    .tag          (j_idx_r),
    .best_value   (best_f),
    .best_ordinal (best_k),
    .best_tag     (best_j)
  );

  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;
  assign bus.alpha_ld_req = alpha_req_r;
  assign bus.start_gen    = start_gen_r;
  assign bus.J_index      = j_idx_r;

endmodule

// File: tb/tb_m_gen_scheduler.sv
// Directed bench for m_gen_scheduler; define M_GEN_SCHED_TIMEOUT_EN to exercise the watchdog (TMO=64).
module tb_m_gen_scheduler;
  import m_gen_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic              busy, done, err;
  logic [FW_DEF-1:0] best_f;
  logic [JW-1:0]     best_j;
  logic [CW_DEF-1:0] best_k;
  int                n_checks = 0;
  int                n_errors = 0;
  int                sg_total = 0;
  int                done_total = 0;

  m_gen_scheduler_if bus ();

`ifdef M_GEN_SCHED_TIMEOUT_EN
  m_gen_scheduler #(.TMO(64)) dut (
`else
  m_gen_scheduler dut (
`endif
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .busy(busy), .bus(bus.master),
    .best_f(best_f), .best_j(best_j), .best_k(best_k), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start_gen === 1'b1) sg_total++;
    if (done === 1'b1) done_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW_DEF-1:0] fval(input int mode, input int j, input int k);
    case (mode)
      0:       return FW_DEF'(100 - k);
      1:       return FW_DEF'(5);
      default: return FW_DEF'(300 + 2 * (j - 9) * (j - 9) - k);
    endcase
  endfunction

  task automatic run_frame(input int ncand, input int mode, input int fdelay, input int abort_j,
                           input int exp_f, input int exp_j, input int exp_k);
    int sg0, d0, t, stray;
    logic [FW_DEF-1:0] ones;
    ones = '1; sg0 = sg_total; d0 = done_total; stray = 0;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0 || bus.alpha_ld_req !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_start busy=%b err=%b alpha_ld_req=%b expected 1 0 1", busy, err, bus.alpha_ld_req);
    end
    bus.alpha_ld_last = 1'b1; tick(); bus.alpha_ld_last = 1'b0;
    bus.x_init_tvalid = 1'b1; tick(); bus.x_init_tvalid = 1'b0;
    for (int j = 0; j < J_DEF; j++) begin
      t = 0;
      while (bus.start_gen !== 1'b1 && t < 100) begin tick(); t++; end
      n_checks++;
      if (bus.start_gen !== 1'b1 || bus.J_index !== JW'(j)) begin
        n_errors++;
        $display("FAIL sweep_start j=%0d start_gen=%b J_index=%0d expected 1 %0d", j, bus.start_gen, bus.J_index, j);
      end
      if (j == abort_j) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.start_gen !== 1'b0 ||
            bus.alpha_ld_req !== 1'b0 || bus.J_index !== '0 || best_f !== ones) begin
          n_errors++;
          $display("FAIL abort_outputs busy=%b done=%b err=%b sg=%b J=%0d best_f=%h expected all idle",
                   busy, done, err, bus.start_gen, bus.J_index, best_f);
        end
        for (int d = 0; d < 5; d++) tick();
        n_checks++;
        if (done_total != d0 || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL abort_no_done done_pulses=%0d busy=%b expected 0 0", done_total - d0, busy);
        end
        return;
      end
      for (int k = 0; k < ncand; k++) begin
        bus.cand_tvalid = 1'b1;
        bus.cand_tlast  = (k == ncand - 1);
        bus.f_tvalid    = (fdelay == 0);
        bus.f_value     = fval(mode, j, k);
        tick();
      end
      bus.cand_tvalid = 1'b0; bus.cand_tlast = 1'b0; bus.f_tvalid = 1'b0;
      if (fdelay > 0) begin
        for (int d = 0; d < fdelay; d++) begin
          tick();
          if (bus.start_gen === 1'b1 || busy !== 1'b1) stray++;
        end
        for (int k = 0; k < ncand; k++) begin
          bus.f_tvalid = 1'b1; bus.f_value = fval(mode, j, k); tick();
        end
        bus.f_tvalid = 1'b0;
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 100) begin tick(); t++; end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_done done=%b busy=%b expected 1 0", done, busy);
    end
    n_checks++;
    if (best_f !== FW_DEF'(exp_f) || best_j !== JW'(exp_j) || best_k !== CW_DEF'(exp_k)) begin
      n_errors++;
      $display("FAIL frame_best got f=%0d j=%0d k=%0d expected f=%0d j=%0d k=%0d",
               best_f, best_j, best_k, exp_f, exp_j, exp_k);
    end
    n_checks++;
    if (err !== 1'b0 || (sg_total - sg0) != J_DEF || stray != 0) begin
      n_errors++;
      $display("FAIL frame_seq err=%b start_gen_pulses=%0d stray=%0d expected 0 %0d 0", err, sg_total - sg0, J_DEF, stray);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || best_f !== FW_DEF'(exp_f)) begin
      n_errors++;
      $display("FAIL done_width done=%b best_f=%0d expected 0 %0d", done, best_f, exp_f);
    end
  endtask

  task automatic test_reset();
    logic [FW_DEF-1:0] ones;
    ones = '1;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.alpha_ld_req !== 1'b0 ||
        bus.start_gen !== 1'b0 || bus.J_index !== '0) begin
      n_errors++;
      $display("FAIL reset_ctrl busy=%b done=%b err=%b alpha=%b sg=%b J=%0d expected all 0",
               busy, done, err, bus.alpha_ld_req, bus.start_gen, bus.J_index);
    end
    n_checks++;
    if (best_f !== ones || best_j !== '0 || best_k !== '0) begin
      n_errors++;
      $display("FAIL reset_best f=%h j=%0d k=%0d expected all-ones 0 0", best_f, best_j, best_k);
    end
  endtask

  task automatic test_basic_frame();
    run_frame(3, 0, 0, -1, 98, 0, 2);
  endtask

  task automatic test_tie();
    run_frame(3, 1, 0, -1, 5, 0, 0);
  endtask

  task automatic test_late_f();
    run_frame(3, 0, 20, -1, 98, 0, 2);
  endtask

  task automatic test_err_idle();
    bus.f_tvalid = 1'b1; bus.f_value = FW_DEF'(1); tick(); bus.f_tvalid = 1'b0; tick();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL err_idle err=%b busy=%b expected 1 0", err, busy);
    end
    run_frame(2, 2, 0, -1, 299, 9, 1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(3, 0, 0, 6, 0, 0, 0);
    run_frame(3, 0, 0, -1, 98, 0, 2);
  endtask

  task automatic test_watchdog();
    int t, d0;
    d0 = done_total;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    bus.alpha_ld_last = 1'b1; tick(); bus.alpha_ld_last = 1'b0;
    bus.x_init_tvalid = 1'b1; tick(); bus.x_init_tvalid = 1'b0;
`ifdef M_GEN_SCHED_TIMEOUT_EN
    t = 0;
    while (done !== 1'b1 && t < 200) begin tick(); t++; end
    n_checks++;
    if (done !== 1'b1 || t != 64 || err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL watchdog done=%b cycles=%0d err=%b busy=%b expected 1 64 1 0", done, t, err, busy);
    end
`else
    for (t = 0; t < 200; t++) tick();
    n_checks++;
    if (busy !== 1'b1 || done_total != d0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL no_watchdog busy=%b done_pulses=%0d err=%b expected 1 0 0", busy, done_total - d0, err);
    end
`endif
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    bus.alpha_ld_last = 1'b0; bus.x_init_tvalid = 1'b0; bus.cand_tvalid = 1'b0;
    bus.cand_tlast = 1'b0; bus.f_tvalid = 1'b0; bus.f_value = '0;
    test_reset();
    test_basic_frame();
    test_tie();
    test_late_f();
    test_err_idle();
    test_reset_mid_frame();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
